// File: rtl/sata_oob_pkg.sv
// Shared SATA OOB timing constants and TX state encoding, used by both the
// OOB encoder and the receive-side OOB decoder so their windows agree.
package sata_oob_pkg;

  localparam int BURST_MIN   = 14;
  localparam int BURST_MAX   = 18;
  localparam int BURST_NOM   = 16;
  localparam int GAPINIT_MIN = 46;
  localparam int GAPINIT_MAX = 50;
  localparam int GAPINIT_NOM = 48;
  localparam int GAPWAKE_MIN = 14;
  localparam int GAPWAKE_MAX = 18;
  localparam int GAPWAKE_NOM = 16;
  localparam int AMOUNT_MIN  = 2;
  localparam int AMOUNT_NOM  = 6;

  typedef enum logic [1:0] {OOB_IDLE, OOB_BURST, OOB_GAP} oob_tx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sata_oob_encoder.sv
// Transmit-side SATA OOB sequencer: emits AMOUNT burst/gap pairs for
// COMINIT/COMRESET or COMWAKE by steering TX electrical idle and ALIGN bursts.
module sata_oob_encoder
  import sata_oob_pkg::*;
#(
  parameter int BURST_LEN   = BURST_NOM,
  parameter int GAPINIT_LEN = GAPINIT_NOM,
  parameter int GAPWAKE_LEN = GAPWAKE_NOM,
  parameter int AMOUNT      = AMOUNT_NOM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cominit_req,
  input  logic       comwake_req,
  output logic       busy,
  output logic       done,
  output logic       txelecidle,
  output logic       txalign,
  output logic [1:0] oob_state
);

  localparam int LEN_W  = $clog2(max3(BURST_LEN, GAPINIT_LEN, GAPWAKE_LEN) + 1);
  localparam int PAIR_W = (AMOUNT > 1) ? $clog2(AMOUNT) : 1;

  localparam logic [LEN_W-1:0]  BURST_LAST   = LEN_W'(BURST_LEN - 1);
  localparam logic [LEN_W-1:0]  GAPINIT_LAST = LEN_W'(GAPINIT_LEN - 1);
  localparam logic [LEN_W-1:0]  GAPWAKE_LAST = LEN_W'(GAPWAKE_LEN - 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST    = PAIR_W'(AMOUNT - 1);

  // Out-of-range timing would fall outside the decoder windows, so refuse to elaborate.
  if (BURST_LEN < BURST_MIN || BURST_LEN > BURST_MAX) begin : g_bad_burst
    $error("sata_oob_encoder: BURST_LEN outside %0d..%0d", BURST_MIN, BURST_MAX);
  end
  if (GAPINIT_LEN < GAPINIT_MIN || GAPINIT_LEN > GAPINIT_MAX) begin : g_bad_gapinit
    $error("sata_oob_encoder: GAPINIT_LEN outside %0d..%0d", GAPINIT_MIN, GAPINIT_MAX);
  end
  if (GAPWAKE_LEN < GAPWAKE_MIN || GAPWAKE_LEN > GAPWAKE_MAX) begin : g_bad_gapwake
    $error("sata_oob_encoder: GAPWAKE_LEN outside %0d..%0d", GAPWAKE_MIN, GAPWAKE_MAX);
  end
  if (AMOUNT < AMOUNT_MIN) begin : g_bad_amount
    $error("sata_oob_encoder: AMOUNT below %0d", AMOUNT_MIN);
  end

  oob_tx_state_t     state, next_state;
  logic [LEN_W-1:0]  len_cnt, len_nxt;
  logic [PAIR_W-1:0] pair_cnt, pair_nxt;
  logic              is_wake, wake_nxt;
  logic              done_nxt;
  logic [LEN_W-1:0]  gap_last;

  assign gap_last  = is_wake ? GAPWAKE_LAST : GAPINIT_LAST;
  assign oob_state = state;

  always_comb begin
    next_state = state;
    len_nxt    = len_cnt;
    pair_nxt   = pair_cnt;
    wake_nxt   = is_wake;
    done_nxt   = 1'b0;
    case (state)
      OOB_IDLE: begin
        if (cominit_req || comwake_req) begin
          next_state = OOB_BURST;
          len_nxt    = '0;
          pair_nxt   = '0;
          wake_nxt   = ~cominit_req;
        end
      end
      OOB_BURST: begin
        if (len_cnt == BURST_LAST) begin
          next_state = OOB_GAP;
          len_nxt    = '0;
        end else begin
          len_nxt = len_cnt + 1'b1;
        end
      end
      OOB_GAP: begin
        if (len_cnt == gap_last) begin
          len_nxt = '0;
          if (pair_cnt == PAIR_LAST) begin
            next_state = OOB_IDLE;
            done_nxt   = 1'b1;
          end else begin
            pair_nxt   = pair_cnt + 1'b1;
            next_state = OOB_BURST;
          end
        end else begin
          len_nxt = len_cnt + 1'b1;
        end
      end
      default: next_state = OOB_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= OOB_IDLE;
      len_cnt    <= '0;
      pair_cnt   <= '0;
      is_wake    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      txelecidle <= 1'b1;
      txalign    <= 1'b0;
    end else begin
      state      <= next_state;
      len_cnt    <= len_nxt;
      pair_cnt   <= pair_nxt;
      is_wake    <= wake_nxt;
      busy       <= (next_state != OOB_IDLE);
      done       <= done_nxt;
      txelecidle <= (next_state != OOB_BURST);
      txalign    <= (next_state == OOB_BURST);
    end
  end

endmodule
